accel_tilt_filter: RTL and testbench
====================================

// Module: accel_tilt_filter
// PURPOSE
//   Consumes signed 8-bit X/Y samples from the SPI accelerometer controller, one per sample_valid pulse.
//   Averages each axis over 2^AVG_LOG2 samples and applies hysteresis thresholds per axis.
//   Emits one-cycle auto-repeating move strobes and level tilt flags that drive the board cursor and LEDs.
// PARAMETERS
//   AVG_LOG2      2        log2 of samples averaged per axis (1..4)
//   THRESH_ON     8'sd24   |avg| >= this enters a tilted state
//   THRESH_OFF    8'sd12   avg magnitude below this returns to CENTER (THRESH_OFF < THRESH_ON)
//   REPEAT_CYC    5000000  cycles between repeat strobes while held tilted (>= 2)
// PORTS
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-high reset
//   sample_valid  in   1  one-cycle pulse, sample_axis/sample_data valid
//   sample_axis   in   2  0=X, 1=Y, 2/3 ignored
//   sample_data   in   8  signed two's-complement acceleration
//   hold          in   1  high: ignore samples, suppress strobes, keep state
//   avg_x         out  8  last completed X average, signed
//   avg_y         out  8  last completed Y average, signed
//   move_right    out  1  X entered/held POS strobe
//   move_left     out  1  X entered/held NEG strobe
//   move_up       out  1  Y entered/held POS strobe
//   move_down     out  1  Y entered/held NEG strobe
//   tilt_state    out  4  {up,down,left,right} level = current axis states
// BEHAVIOUR
//   - One clock domain; reset is synchronous and active-high.
//   - Reset: avg_x=avg_y=0, all strobes 0, tilt_state=0, both axes CENTER, accumulators/counts/repeat timers 0.
//   - Reset mid-accumulation discards the partial sum.
//   - sample_valid is ignored in the reset cycle.
//   - Accumulation, per axis (X, Y independent):
//     - Accumulator is signed, 8+AVG_LOG2 bits; each sample is sign-extended and added.
//     - On the sample that makes the count 2^AVG_LOG2, avg = (acc+sample) >>> AVG_LOG2 (arithmetic shift).
//     - avg is registered on the next edge (1-cycle latency); acc and count clear in the same cycle.
//     - Samples with axis 2/3 are dropped without side effects.
//     - Extremes (-128 x16 = -2048) fit without overflow.
//   - Axis FSM, evaluated only in the cycle a new avg is registered; uses the new avg value:
//     - CENTER: avg >= THRESH_ON -> POS; avg <= -THRESH_ON -> NEG; else stay.
//     - POS: avg <= -THRESH_ON -> NEG; else avg < THRESH_OFF -> CENTER; else stay.
//     - NEG: avg >= THRESH_ON -> POS; else avg > -THRESH_OFF -> CENTER; else stay.
//     - Boundaries: avg == THRESH_ON enters; avg == THRESH_OFF holds POS; avg == -THRESH_OFF holds NEG.
//   - Strobes:
//     - One-cycle pulse in the cycle the FSM enters POS/NEG (same cycle avg updates).
//     - That entry also resets the axis repeat timer to 0.
//     - While the state persists, the timer counts every cycle and pulses again when it reaches REPEAT_CYC-1, then wraps to 0.
//     - CENTER clears the timer and produces no strobe.
//     - X and Y strobe independently; simultaneous strobes are allowed.
//   - hold=1: samples dropped, timers frozen, all strobes forced 0, FSM/avg/tilt_state unchanged.
//     - On hold release, timers resume from their frozen value.
//   - tilt_state mirrors FSM state combinationally from registers (no extra latency).
// TESTING (AVG_LOG2=2, THRESH_ON=24, THRESH_OFF=12, REPEAT_CYC=16)
//   1. Reset, four X samples of 30 -> avg_x=30 one cycle after the 4th; move_right pulses once that cycle; tilt_state=4'b0001.
//   2. Hold X at 30 for 40 cycles, no new samples -> move_right pulses at 16 and 32 cycles after entry, never otherwise.
//   3. From POS, X averages of 12 then 11 -> stays POS after 12, returns to CENTER after 11; no strobe; tilt_state=0.
//   4. Four Y samples of -128 -> avg_y=-128 (8'h80), move_down pulse, tilt_state=4'b0100; X untouched.
//   5. X POS, then four X samples of -40 -> direct POS->NEG, move_left pulse, avg_x=-40.
//   6. Two X samples of 30, assert reset, release, then four samples of 0 -> avg_x=0, no strobe (partial discarded).
//      Additionally, axis=2 samples and samples with hold=1 change nothing.

Source files
------------

// File: rtl/accel_tilt_filter.sv
// Two-axis accelerometer tilt filter: block-averages X/Y samples, classifies each
// axis with hysteresis, and emits entry/auto-repeat move strobes plus level tilt flags.
module accel_tilt_filter #(
  parameter int                AVG_LOG2   = 2,
  parameter logic signed [7:0] THRESH_ON  = 8'sd24,
  parameter logic signed [7:0] THRESH_OFF = 8'sd12,
  parameter int                REPEAT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [1:0]        sample_axis,
  input  logic signed [7:0] sample_data,
  input  logic              hold,
  output logic signed [7:0] avg_x,
  output logic signed [7:0] avg_y,
  output logic              move_right,
  output logic              move_left,
  output logic              move_up,
  output logic              move_down,
  output logic [3:0]        tilt_state
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int TMR_W = $clog2(REPEAT_CYC);
  localparam logic signed [7:0] NEG_ON  = -THRESH_ON;
  localparam logic signed [7:0] NEG_OFF = -THRESH_OFF;

  typedef enum logic [1:0] {CENTER, POS, NEG} axis_state_t;

  function automatic logic signed [7:0] avg_of(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> AVG_LOG2;
    return shifted[7:0];
  endfunction

  // A reversal past the opposite ON threshold jumps straight across without visiting CENTER.
  function automatic axis_state_t next_state(input axis_state_t cur,
                                             input logic signed [7:0] a);
    axis_state_t nxt;
    nxt = cur;
    case (cur)
      CENTER: begin
        if (a >= THRESH_ON)   nxt = POS;
        else if (a <= NEG_ON) nxt = NEG;
      end
      POS: begin
        if (a <= NEG_ON)          nxt = NEG;
        else if (a < THRESH_OFF)  nxt = CENTER;
      end
      NEG: begin
        if (a >= THRESH_ON)    nxt = POS;
        else if (a > NEG_OFF)  nxt = CENTER;
      end
      default: nxt = CENTER;
    endcase
    return nxt;
  endfunction

  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic signed [ACC_W-1:0] acc;
    logic [AVG_LOG2-1:0]     cnt;
    logic signed [7:0]       avg;
    axis_state_t             state;
    logic [TMR_W-1:0]        tmr;
    logic                    str_pos;
    logic                    str_neg;

    logic                    take;
    logic                    done;
    logic signed [ACC_W-1:0] sum;
    logic signed [7:0]       avg_new;
    axis_state_t             state_new;

    assign take      = sample_valid && !hold && (sample_axis == 2'(a));
    assign done      = take && (cnt == '1);
    assign sum       = acc + {{AVG_LOG2{sample_data[7]}}, sample_data};
    assign avg_new   = avg_of(sum);
    assign state_new = next_state(state, avg_new);

    always_ff @(posedge clk) begin
      if (reset) begin
        acc     <= '0;
        cnt     <= '0;
        avg     <= '0;
        state   <= CENTER;
        tmr     <= '0;
        str_pos <= 1'b0;
        str_neg <= 1'b0;
      end else begin
        str_pos <= 1'b0;
        str_neg <= 1'b0;
        if (done) begin
          acc <= '0;
          cnt <= '0;
          avg <= avg_new;
        end else if (take) begin
          acc <= sum;
          cnt <= cnt + AVG_LOG2'(1);
        end
        // A state change outranks a repeat that would fire on the same edge.
        if (!hold) begin
          if (done && (state_new != state)) begin
            state   <= state_new;
            tmr     <= '0;
            str_pos <= (state_new == POS);
            str_neg <= (state_new == NEG);
          end else if (state != CENTER) begin
            if (tmr == TMR_W'(REPEAT_CYC - 1)) begin
              tmr     <= '0;
              str_pos <= (state == POS);
              str_neg <= (state == NEG);
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end else begin
            tmr <= '0;
          end
        end
      end
    end
  end

  assign avg_x      = g_axis[0].avg;
  assign avg_y      = g_axis[1].avg;
  assign move_right = g_axis[0].str_pos;
  assign move_left  = g_axis[0].str_neg;
  assign move_up    = g_axis[1].str_pos;
  assign move_down  = g_axis[1].str_neg;
  assign tilt_state = {g_axis[1].state == POS, g_axis[1].state == NEG,
                       g_axis[0].state == NEG, g_axis[0].state == POS};

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Directed bench for accel_tilt_filter with REPEAT_CYC shortened to 16 cycles.
module tb_accel_tilt_filter;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [1:0]        sample_axis;
  logic signed [7:0] sample_data;
  logic              hold;
  logic signed [7:0] avg_x;
  logic signed [7:0] avg_y;
  logic              move_right;
  logic              move_left;
  logic              move_up;
  logic              move_down;
  logic [3:0]        tilt_state;

  int total = 0;
  int bad   = 0;

  accel_tilt_filter #(
    .AVG_LOG2  (2),
    .THRESH_ON (8'sd24),
    .THRESH_OFF(8'sd12),
    .REPEAT_CYC(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_axis (sample_axis),
    .sample_data (sample_data),
    .hold        (hold),
    .avg_x       (avg_x),
    .avg_y       (avg_y),
    .move_right  (move_right),
    .move_left   (move_left),
    .move_up     (move_up),
    .move_down   (move_down),
    .tilt_state  (tilt_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every task leaves the bench 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ax, input logic signed [7:0] d);
    sample_valid = 1'b1;
    sample_axis  = ax;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_axis  = 2'd0;
    sample_data  = '0;
    hold         = 1'b0;
    repeat (2) step();
    chk("rst_avg_x", avg_x, 0);
    chk("rst_avg_y", avg_y, 0);
    chk("rst_tilt", tilt_state, 0);
    chk("rst_strobes", {move_right, move_left, move_up, move_down}, 0);
    reset = 1'b0;

    // 1: four X samples of 30 enter POS
    repeat (3) send(2'd0, 8'sd30);
    chk("t1_avg_before", avg_x, 0);
    send(2'd0, 8'sd30);
    chk("t1_avg_x", avg_x, 30);
    chk("t1_right", move_right, 1);
    chk("t1_tilt", tilt_state, 4'b0001);

    // 2: held tilted, repeats exactly at +16 and +32
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("t2_rep_%0d", k), move_right, ((k == 16) || (k == 32)) ? 1 : 0);
    end
    chk("t2_tilt", tilt_state, 4'b0001);

    // 3: average 12 holds POS, 11 drops to CENTER (repeat would coincide on the last edge)
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 8'sd12);
      chk("t3_no_strobe_a", move_right, 0);
    end
    chk("t3_avg12", avg_x, 12);
    chk("t3_tilt12", tilt_state, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 8'sd11);
      chk("t3_no_strobe_b", move_right, 0);
    end
    chk("t3_avg11", avg_x, 11);
    chk("t3_tilt11", tilt_state, 4'b0000);
    chk("t3_left", move_left, 0);

    // 4: Y at full negative scale, with an axis-2 sample and a held sample interleaved
    send(2'd1, -8'sd128);
    send(2'd1, -8'sd128);
    send(2'd2, 8'sd100);
    hold = 1'b1;
    send(2'd1, 8'sd127);
    hold = 1'b0;
    chk("t4_avg_y_partial", avg_y, 0);
    send(2'd1, -8'sd128);
    send(2'd1, -8'sd128);
    chk("t4_avg_y", avg_y, -128);
    chk("t4_avg_y_hex", avg_y[7:0], 8'h80);
    chk("t4_down", move_down, 1);
    chk("t4_up", move_up, 0);
    chk("t4_tilt", tilt_state, 4'b0100);
    chk("t4_avg_x", avg_x, 11);

    // hold freezes the repeat timer for 5 cycles, so the repeat lands at +21
    repeat (4) step();
    hold = 1'b1;
    send(2'd1, 8'sd127);
    repeat (4) begin
      step();
      chk("t4_hold_down", move_down, 0);
    end
    chk("t4_hold_avg_y", avg_y, -128);
    chk("t4_hold_tilt", tilt_state, 4'b0100);
    hold = 1'b0;
    for (int j = 10; j <= 21; j++) begin
      step();
      chk($sformatf("t4_rep_%0d", j), move_down, (j == 21) ? 1 : 0);
    end

    // 5: X POS, then straight to NEG
    repeat (4) send(2'd0, 8'sd30);
    chk("t5_right", move_right, 1);
    chk("t5_tilt_pos", tilt_state, 4'b0101);
    repeat (4) send(2'd0, -8'sd40);
    chk("t5_avg_x", avg_x, -40);
    chk("t5_left", move_left, 1);
    chk("t5_right_off", move_right, 0);
    chk("t5_tilt_neg", tilt_state, 4'b0110);

    // 6: reset discards a partial sum and a sample presented during reset
    send(2'd0, 8'sd30);
    send(2'd0, 8'sd30);
    reset = 1'b1;
    send(2'd0, 8'sd100);
    reset = 1'b0;
    chk("t6_rst_avg_x", avg_x, 0);
    chk("t6_rst_tilt", tilt_state, 0);
    repeat (3) send(2'd0, 8'sd0);
    chk("t6_avg_mid", avg_x, 0);
    send(2'd0, 8'sd0);
    chk("t6_avg_x", avg_x, 0);
    chk("t6_strobes", {move_right, move_left, move_up, move_down}, 0);
    chk("t6_tilt", tilt_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
